// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded control and operands into EX,
// resolves the destination register, and inserts bubbles on load-use hazards.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_load_upper,
    input  logic              id_jal,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_branch,
    input  logic              id_syscall,
    input  logic [1:0]        id_jump,
    input  logic [4:0]        id_alu_control,
    input  logic [3:0]        id_bcu_control,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic              stall_in,
    input  logic              flush,
    output logic              ex_valid,
    output logic              ex_load_upper,
    output logic              ex_jal,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic              ex_branch,
    output logic              ex_syscall,
    output logic [1:0]        ex_jump,
    output logic [4:0]        ex_alu_control,
    output logic [3:0]        ex_bcu_control,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_shamt,
    output logic [4:0]        ex_write_reg,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm_ext,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic              load_use_stall,
    output logic              stall_out,
    output logic [CNT_W-1:0]  bubble_count
);

    logic       uses_rs;
    logic       uses_rt;
    logic       rs_hit;
    logic       rt_hit;
    logic       bubble;
    logic [4:0] write_reg_d;

    assign uses_rs = !(id_load_upper | (id_jump == 2'b01));
    assign uses_rt = !id_alu_src | id_mem_write | id_branch;
    assign rs_hit  = uses_rs & (ex_write_reg == id_rs);
    assign rt_hit  = uses_rt & (ex_write_reg == id_rt);

    // A flushed ID slot is killed anyway, so it never raises a hazard.
    assign load_use_stall = ex_valid & ex_mem_to_reg
                          & (ex_write_reg != 5'd0)
                          & id_valid & !flush
                          & (rs_hit | rt_hit);

    assign stall_out = load_use_stall | stall_in;
    assign bubble    = flush | load_use_stall;

    assign write_reg_d = id_reg_dst ? id_rd
                       : (id_jal ? 5'd31 : id_rt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_load_upper  <= 1'b0;
            ex_jal         <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_alu_src     <= 1'b0;
            ex_reg_dst     <= 1'b0;
            ex_branch      <= 1'b0;
            ex_syscall     <= 1'b0;
            ex_jump        <= 2'b00;
            ex_alu_control <= 5'd0;
            ex_bcu_control <= 4'd0;
            ex_rs          <= 5'd0;
            ex_rt          <= 5'd0;
            ex_shamt       <= 5'd0;
            ex_write_reg   <= 5'd0;
            ex_rs_data     <= '0;
            ex_rt_data     <= '0;
            ex_imm_ext     <= '0;
            ex_pc_plus4    <= '0;
            bubble_count   <= '0;
        end else if (!stall_in) begin
            if (bubble) begin
                ex_valid       <= 1'b0;
                ex_load_upper  <= 1'b0;
                ex_jal         <= 1'b0;
                ex_reg_write   <= 1'b0;
                ex_mem_to_reg  <= 1'b0;
                ex_mem_write   <= 1'b0;
                ex_alu_src     <= 1'b0;
                ex_reg_dst     <= 1'b0;
                ex_branch      <= 1'b0;
                ex_syscall     <= 1'b0;
                ex_jump        <= 2'b00;
                ex_alu_control <= 5'd0;
                ex_bcu_control <= 4'd0;
                ex_rs          <= 5'd0;
                ex_rt          <= 5'd0;
                ex_shamt       <= 5'd0;
                ex_write_reg   <= 5'd0;
                ex_rs_data     <= '0;
                ex_rt_data     <= '0;
                ex_imm_ext     <= '0;
                ex_pc_plus4    <= '0;
                if (bubble_count != {CNT_W{1'b1}})
                    bubble_count <= bubble_count + 1'b1;
            end else begin
                ex_valid       <= id_valid;
                ex_load_upper  <= id_load_upper;
                ex_jal         <= id_jal;
                ex_reg_write   <= id_reg_write;
                ex_mem_to_reg  <= id_mem_to_reg;
                ex_mem_write   <= id_mem_write;
                ex_alu_src     <= id_alu_src;
                ex_reg_dst     <= id_reg_dst;
                ex_branch      <= id_branch;
                ex_syscall     <= id_syscall;
                ex_jump        <= id_jump;
                ex_alu_control <= id_alu_control;
                ex_bcu_control <= id_bcu_control;
                ex_rs          <= id_rs;
                ex_rt          <= id_rt;
                ex_shamt       <= id_shamt;
                ex_write_reg   <= write_reg_d;
                ex_rs_data     <= id_rs_data;
                ex_rt_data     <= id_rt_data;
                ex_imm_ext     <= id_imm_ext;
                ex_pc_plus4    <= id_pc_plus4;
            end
        end
    end

endmodule
